text_screen_writer: RTL
=======================

TEXT_SCREEN_WRITER -- requirements
Module: text_screen_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning characters per row.
REQ-002 SHALL have parameter ROWS, default 24, meaning rows on screen.
REQ-003 SHALL have parameter ROW_BITS, default 5, meaning cursor_y width; ROW_BITS SHALL be at least clog2(ROWS).
REQ-004 SHALL have parameter COL_BITS, default 7, meaning cursor_x width; COL_BITS SHALL be at least clog2(COLS).
REQ-005 SHALL have parameter ADDR_BITS, default 11, meaning char buffer address width; ADDR_BITS SHALL be at least clog2(COLS*ROWS).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have ports in_data, input, 8 bits; in_valid, input, 1 bit; in_ready, output, 1 bit: the byte stream from the uart pipeline.
REQ-009 SHALL have ports new_char, output, 8 bits; new_char_address, output, ADDR_BITS; new_char_wen, output, 1 bit: the char buffer write.
REQ-010 SHALL have ports new_first_char, output, ADDR_BITS; new_first_char_wen, output, 1 bit: the scroll offset write.
REQ-011 SHALL have ports new_cursor_x, output, COL_BITS; new_cursor_y, output, ROW_BITS; new_cursor_wen, output, 1 bit: the cursor write.

Function
REQ-012 SHALL accept a byte only on a cycle where in_valid and in_ready are both high; in_ready SHALL be high only in state IDLE.
REQ-013 SHALL implement the states IDLE, EXEC and CLEAR; acceptance moves IDLE to EXEC, EXEC lasts exactly 1 cycle, and EXEC goes to IDLE, or to CLEAR on a scroll.
REQ-014 SHALL treat a printable byte (0x20-0x7E) in EXEC as follows: new_char=byte; new_char_address=(first_char + y*COLS + x) mod (COLS*ROWS); new_char_wen pulses for 1 cycle.
REQ-015 SHALL advance the cursor after a printable byte when x<COLS-1: x+1.
REQ-016 SHALL handle x==COLS-1 after a printable byte as specified in Configuration (REQ-028, REQ-029).
REQ-017 SHALL handle CR (0x0D) by setting x=0.
REQ-018 SHALL handle LF (0x0A) by setting y=y+1 when y<ROWS-1, and otherwise by scrolling.
REQ-019 SHALL handle BS (0x08) by setting x=x-1 when x>0; at x=0 it SHALL have no effect.
REQ-020 SHALL drive new_cursor_x and new_cursor_y with the updated position and pulse new_cursor_wen for 1 cycle in EXEC for every CR, LF, BS or printable byte, even when the position is unchanged.
REQ-021 SHALL perform no write and no pulse in EXEC for any other byte, including 0x7F and 0x80-0xFF.
REQ-022 SHALL perform a scroll in EXEC as follows: first_char=(first_char+COLS) mod (COLS*ROWS); new_first_char carries the new value; new_first_char_wen pulses for 1 cycle; y stays at ROWS-1.
REQ-023 SHALL, in CLEAR, write 0x20 to the COLS addresses of the new bottom row, one per cycle in ascending column order, with address wrap mod COLS*ROWS, then return to IDLE; in_ready SHALL stay low throughout CLEAR.
REQ-024 SHALL have a throughput of 1 byte per 2 cycles for non-scrolling bytes, and 2+COLS cycles for a scrolling byte.
REQ-025 SHALL compute all address arithmetic at ADDR_BITS+1 bits, then reduce with a single conditional subtract; no multiplier is allowed, and the row base SHALL be tracked incrementally.

Reset
REQ-026 SHALL, while reset is high, put the block in state IDLE with x=0, y=0 and first_char=0; in_ready, new_char_wen, new_first_char_wen and new_cursor_wen SHALL be 0; new_char, new_char_address, new_first_char, new_cursor_x and new_cursor_y SHALL be 0.
REQ-027 SHALL, if reset asserts mid-CLEAR or mid-EXEC, abort immediately with no further writes; the partial row is left as written.

Configuration
REQ-028 SHALL, when macro TEXT_SCREEN_WRITER_AUTO_WRAP_EN is defined, handle a printable byte at x==COLS-1 by setting x=0 and then applying the LF rule, including a scroll when y==ROWS-1.
REQ-029 SHALL, when the macro is undefined, handle a printable byte at x==COLS-1 by keeping x at COLS-1, so later printable bytes overwrite the last column.

Structure
REQ-030 SHALL keep the state enum and the character constants (SPACE 0x20, CR, LF, BS, PRINT_MIN 0x20, PRINT_MAX 0x7E) in a shared package, text_screen_pkg.
REQ-031 SHALL remain a single module with no sub-module; the state machine and the address tracking live together.

Verification
REQ-032 SHALL cover: after reset, 'A'(0x41) -> 1 cycle later new_char_wen=1, new_char=0x41, address=0; cursor_wen with x=1, y=0.
REQ-033 SHALL cover: x=79 (COLS=80) and 'B' with AUTO_WRAP_EN defined -> address=79, then cursor x=0, y=1.
REQ-034 SHALL cover: x=79 and 'B' with AUTO_WRAP_EN undefined -> address=79, then cursor x=79, y=0.
REQ-035 SHALL cover: y=23, then LF -> new_first_char=80 with a 1-cycle pulse, followed by 80 writes of 0x20 to addresses 0..79, with in_ready low for 80 cycles.
REQ-036 SHALL cover: 24 scrolls from reset (first_char back to 0), then a 25th LF -> new_first_char=80 and clear addresses 0..79 (wrap verified).
REQ-037 SHALL cover: BS at x=0 -> cursor_wen with x=0; byte 0x07 -> no wen pulses; reset asserted on CLEAR cycle 10 -> all wens 0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/text_screen_pkg.sv
// Shared state encoding and character constants for the text screen writer.
// Latency and backpressure: not applicable (types and constants only).
package text_screen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [7:0] SPACE     = 8'h20;
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;
    localparam logic [7:0] BS        = 8'h08;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

endpackage

// File: rtl/text_screen_writer.sv
// Byte stream to char-buffer/cursor/scroll writes; TEXT_SCREEN_WRITER_AUTO_WRAP_EN wraps at last column.
// Latency: writes appear in EXEC, 1 cycle after acceptance; a scroll adds COLS clear cycles.
// Backpressure: in_ready only in IDLE, so 1 byte per 2 cycles, 2+COLS for a scrolling byte.
module text_screen_writer
    import text_screen_pkg::*;
#(
    parameter int COLS      = 80,
    parameter int ROWS      = 24,
    parameter int ROW_BITS  = 5,
    parameter int COL_BITS  = 7,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           new_char,
    output logic [ADDR_BITS-1:0] new_char_address,
    output logic                 new_char_wen,
    output logic [ADDR_BITS-1:0] new_first_char,
    output logic                 new_first_char_wen,
    output logic [COL_BITS-1:0]  new_cursor_x,
    output logic [ROW_BITS-1:0]  new_cursor_y,
    output logic                 new_cursor_wen
);

    localparam int AW1 = ADDR_BITS + 1;
    localparam logic [AW1-1:0]      SCREEN = AW1'(COLS * ROWS);
    localparam logic [AW1-1:0]      COLS_A = AW1'(COLS);
    localparam logic [COL_BITS-1:0] X_MAX  = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] Y_MAX  = ROW_BITS'(ROWS - 1);

    // Both operands are below SCREEN, so one conditional subtract is enough.
    function automatic logic [ADDR_BITS-1:0] wrap_add(input logic [ADDR_BITS-1:0] a,
                                                       input logic [AW1-1:0] b);
        logic [AW1-1:0] s;
        s = {1'b0, a} + b;
        if (s >= SCREEN) s = s - SCREEN;
        return s[ADDR_BITS-1:0];
    endfunction

    state_t                state, state_nxt;
    logic [COL_BITS-1:0]   x, x_nxt, clr_col, clr_nxt;
    logic [ROW_BITS-1:0]   y, y_nxt;
    logic [ADDR_BITS-1:0]  first_char, fc_nxt;
    logic [ADDR_BITS-1:0]  row_base, rb_nxt;   // first_char + y*COLS, kept incrementally
    logic [7:0]            byte_q;
    logic                  do_lf;
    logic                  cursor_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            first_char <= '0;
            row_base   <= '0;
            clr_col    <= '0;
            byte_q     <= '0;
        end else begin
            state      <= state_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            first_char <= fc_nxt;
            row_base   <= rb_nxt;
            clr_col    <= clr_nxt;
            if (in_valid && in_ready) byte_q <= in_data;
        end
    end

    always_comb begin
        state_nxt          = state;
        x_nxt              = x;
        y_nxt              = y;
        fc_nxt             = first_char;
        rb_nxt             = row_base;
        clr_nxt            = clr_col;
        do_lf              = 1'b0;
        cursor_evt         = 1'b0;
        in_ready           = 1'b0;
        new_char           = '0;
        new_char_address   = '0;
        new_char_wen       = 1'b0;
        new_first_char     = '0;
        new_first_char_wen = 1'b0;
        new_cursor_x       = '0;
        new_cursor_y       = '0;
        new_cursor_wen     = 1'b0;

        case (state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = IDLE;
                if (byte_q >= PRINT_MIN && byte_q <= PRINT_MAX) begin
                    new_char         = byte_q;
                    new_char_address = wrap_add(row_base, AW1'(x));
                    new_char_wen     = 1'b1;
                    cursor_evt       = 1'b1;
                    if (x < X_MAX) begin
                        x_nxt = x + 1'b1;
                    end else begin
`ifdef TEXT_SCREEN_WRITER_AUTO_WRAP_EN
                        x_nxt = '0;
                        do_lf = 1'b1;
`else
                        x_nxt = X_MAX;
`endif
                    end
                end else if (byte_q == CR) begin
                    x_nxt      = '0;
                    cursor_evt = 1'b1;
                end else if (byte_q == LF) begin
                    do_lf      = 1'b1;
                    cursor_evt = 1'b1;
                end else if (byte_q == BS) begin
                    if (x != '0) x_nxt = x - 1'b1;
                    cursor_evt = 1'b1;
                end

                if (do_lf) begin
                    // On a scroll the old top row becomes the new bottom row.
                    rb_nxt = wrap_add(row_base, COLS_A);
                    if (y < Y_MAX) begin
                        y_nxt = y + 1'b1;
                    end else begin
                        fc_nxt             = wrap_add(first_char, COLS_A);
                        new_first_char     = fc_nxt;
                        new_first_char_wen = 1'b1;
                        clr_nxt            = '0;
                        state_nxt          = CLEAR;
                    end
                end

                if (cursor_evt) begin
                    new_cursor_x   = x_nxt;
                    new_cursor_y   = y_nxt;
                    new_cursor_wen = 1'b1;
                end
            end
            CLEAR: begin
                new_char         = SPACE;
                new_char_address = wrap_add(row_base, AW1'(clr_col));
                new_char_wen     = 1'b1;
                clr_nxt          = clr_col + 1'b1;
                if (clr_col == X_MAX) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
